poly_result_display: RTL
========================

// Module: poly_result_display
// PURPOSE
//  Output-side counterpart of the board operand loader. Accepts one finished product
//  polynomial from the multiplier core over a valid/ready handshake and buffers it.
//  Presents the product on the 16 board LEDs one coefficient per manual step.
//  Sits between the multiplier core and the LED pins in the FPGA top level.
// PARAMETERS
//  N_IN    4    terms per operand polynomial
//  N_OUT   7    product terms; fixed at 2*N_IN-1
//  COEF_W  10   product coefficient width (4b x 4b x 4 terms -> max 900); must be <=12
//  LED_W   16   LED bus width
// PORTS
//  man_clk    in   1             single clock for the block
//  man_reset  in   1             synchronous, active-high reset
//  step       in   1             step-button level, already synchronised; rising edge detected here
//  res_valid  in   1             product available on res_data
//  res_ready  out  1             block can accept a product
//  res_data   in   N_OUT*COEF_W  res_data[k*COEF_W +: COEF_W] = coefficient of x^k
//  LED        out  LED_W         display word
//  busy       out  1             product held, display in progress (SHOW or DONE)
//  done       out  1             all coefficients have been shown
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, step_q=0, coefficient bank cleared to 0, LED=0,
//    res_ready=1, busy=0, done=0. Reset mid-display aborts it; the held product is lost.
//  - Step detection: step_q <= step every cycle; step_rise = step & ~step_q.
//    A held button gives exactly one advance.
//  - All outputs are registered.
//  - IDLE
//    - res_ready=1, LED=0.
//    - On res_valid & res_ready: capture the whole res_data into the bank, idx<=0, go SHOW.
//    - res_ready is 0 from the next cycle. LED = {4'd0, zext(coef0)} one cycle after the handshake edge.
//  - SHOW
//    - LED = {idx[3:0], zext12(bank[idx])}; busy=1.
//    - On step_rise with idx<N_OUT-1: idx++. The LED updates the cycle after the edge.
//    - On step_rise with idx==N_OUT-1: go DONE.
//  - DONE
//    - LED = 16'hF000; done=1; busy=1.
//    - On step_rise: go IDLE; res_ready=1, LED=0 and done=0 next cycle.
//  - Handshake: res_valid while res_ready=0 is ignored; the producer holds res_data and
//    res_valid until accepted. A step_rise in IDLE is a no-op. A step_rise in the same
//    cycle as an IDLE handshake: the capture wins and the step is discarded.
//  - No arithmetic on the data; coefficients are zero-extended from COEF_W to 12 bits.
//  - Elaboration error if COEF_W > 12 or N_OUT > 15.
// STRUCTURE
//  - poly_pkg: N_IN, N_OUT, COEF_W, LED_DONE=16'hF000, state encoding (IDLE/SHOW/DONE).
//  - One sub-module: step_edge (step_q register + rising-edge pulse), reused by the operand loader.
//  - FSM, index counter and bank are inline.
// TESTING
//  - Reset mid-SHOW (idx=3) -> next cycle LED=0, res_ready=1, busy=0, done=0;
//    after a new handshake, idx restarts at 0.
//  - Handshake res_data for (1+x^2)(1+2x+3x^2+4x^3) = {0,4,3,6,4,2,1} (x^6..x^0)
//    -> LED 0x0001, then one step each: 0x1002, 0x2004, 0x3006, 0x4003, 0x5004, 0x6000.
//    One more step -> 0xF000 with done=1; one more -> LED=0, res_ready=1.
//  - step held high for 20 cycles in SHOW -> idx advances exactly once.
//  - res_valid pulsed during SHOW with different data -> ignored; the displayed values are unchanged.
//  - Handshake and step_rise in the same IDLE cycle -> LED=0x0000+coef0, idx=0 (no skip).
//  - All-15 operands (coef x^3 = 900) -> LED at idx 3 = 0x3384; no truncation.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared constants and types for the polynomial board I/O blocks.
// Sizes, the DONE display word and the result-display state encoding.
package poly_pkg;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 2 * N_IN - 1;
    localparam int COEF_W = 10;
    localparam int LED_W  = 16;

    localparam logic [15:0] LED_DONE = 16'hF000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_DONE = 2'd2
    } disp_state_t;

    // Display word while showing a coefficient: index nibble over 12-bit value.
    function automatic logic [15:0] show_word(input logic [3:0] idx, input logic [11:0] coef);
        return {idx, coef};
    endfunction

endpackage

// File: rtl/step_edge.sv
// Rising-edge detector for an already-synchronised step button level.
// One-cycle pulse on the first high cycle; a held button yields a single pulse.
module step_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic step_i,
    output logic rise_o
);

    logic step_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_i;
        end
    end

    assign rise_o = step_i & ~step_q;

endmodule

// File: rtl/poly_result_display.sv
// Buffers one product polynomial and steps its coefficients onto the board LEDs.
// Registered outputs; accepts a product only in IDLE, res_ready low while a product is held.
module poly_result_display
    import poly_pkg::*;
#(
    parameter int N_IN_P   = N_IN,
    parameter int N_OUT_P  = N_OUT,
    parameter int COEF_W_P = COEF_W,
    parameter int LED_W_P  = LED_W
) (
    input  logic                          man_clk,
    input  logic                          man_reset,
    input  logic                          step,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [N_OUT_P*COEF_W_P-1:0]   res_data,
    output logic [LED_W_P-1:0]            LED,
    output logic                          busy,
    output logic                          done
);

    if (COEF_W_P > 12) begin : g_bad_coef_w
        $error("poly_result_display: COEF_W must be <= 12");
    end
    if (N_OUT_P > 15) begin : g_bad_n_out
        $error("poly_result_display: N_OUT must be <= 15");
    end
    if (N_OUT_P != 2 * N_IN_P - 1) begin : g_bad_n_in
        $error("poly_result_display: N_OUT must equal 2*N_IN-1");
    end
    if (LED_W_P != 16) begin : g_bad_led_w
        $error("poly_result_display: LED word layout assumes 16 LEDs");
    end

    logic step_rise;

    step_edge u_step_edge (
        .clk_i  (man_clk),
        .rst_i  (man_reset),
        .step_i (step),
        .rise_o (step_rise)
    );

    disp_state_t                      state_q, state_d;
    logic [3:0]                       idx_q, idx_d;
    logic [N_OUT_P*COEF_W_P-1:0]      bank_q, bank_d;
    logic [LED_W_P-1:0]               led_q, led_d;
    logic                             ready_q, ready_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic [COEF_W_P-1:0]              coef_sel;
    logic [11:0]                      coef12;

    always_ff @(posedge man_clk) begin
        if (man_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bank_q  <= '0;
            led_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bank_q  <= bank_d;
            led_q   <= led_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state. A step in the capture cycle is dropped because IDLE ignores steps.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bank_d  = bank_q;
        case (state_q)
            ST_IDLE: begin
                if (res_valid && ready_q) begin
                    bank_d  = res_data;
                    idx_d   = '0;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (step_rise) begin
                    if (idx_q == 4'(N_OUT_P - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                if (step_rise) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so they land in registers
    // in the same cycle the state changes.
    always_comb begin
        coef_sel = bank_d[32'(idx_d) * COEF_W_P +: COEF_W_P];
        coef12   = '0;
        coef12[COEF_W_P-1:0] = coef_sel;
        led_d    = '0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_SHOW: begin
                led_d  = show_word(idx_d, coef12);
                busy_d = 1'b1;
            end
            ST_DONE: begin
                led_d  = LED_DONE;
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

    assign res_ready = ready_q;
    assign LED       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
